// File: rtl/sme_share_store.sv
// Storage for the non-zero shares of masked SME registers, with a zeroisation
// sweep and a background refresh engine that remasks registers using RNG words.
module sme_share_store #(
  parameter int XLEN           = 32,
  parameter int SMAX           = 4,
  parameter int NREGS          = 16,
  parameter int REFRESH_PERIOD = 64,
  localparam int SW            = (SMAX-1)*XLEN,
  localparam int AW            = $clog2(NREGS)
) (
  input  logic            g_clk,
  input  logic            g_reset,
  input  logic [3:0]      smectl_d,
  input  logic            smectl_t,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [SW-1:0]   rs1_rdata,
  output logic [SW-1:0]   rs2_rdata,
  input  logic            wr_valid,
  output logic            wr_ready,
  input  logic [AW-1:0]   wr_addr,
  input  logic [SMAX-2:0] wr_sel,
  input  logic [SW-1:0]   wr_data,
  input  logic            zero_req,
  input  logic            refresh_en,
  input  logic            rng_valid,
  output logic            rng_ready,
  input  logic [SW-1:0]   rng_data,
  output logic            busy,
  output logic            refresh_step
);

  localparam int CW = $clog2(REFRESH_PERIOD+1);

  typedef enum logic [1:0] {ST_ZERO, ST_IDLE, ST_WAIT, ST_REFRESH} state_t;

  state_t          state, state_n;
  logic [AW-1:0]   ptr, ptr_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic            step_n;
  logic            wr_fire, rf_fire;
  logic [SW-1:0]   mem [NREGS];

  // Remask one register: the first Ds-1 shares absorb r_k, the last active
  // share absorbs the inverse combination so the unmasked value is unchanged.
  function automatic logic [SW-1:0] refresh_shares(input logic [SW-1:0] s,
                                                   input logic [SW-1:0] r,
                                                   input logic [3:0]    d,
                                                   input logic          t);
    logic [SW-1:0]   res;
    logic [XLEN-1:0] acc_x, acc_s;
    int              ds;
    res   = s;
    acc_x = '0;
    acc_s = '0;
    ds    = (int'(d) > SMAX) ? SMAX-1 : int'(d)-1;
    if (ds >= 2) begin
      for (int k = 1; k < SMAX; k++) begin
        if (k < ds) begin
          res[(k-1)*XLEN +: XLEN] = t ? s[(k-1)*XLEN +: XLEN] + r[(k-1)*XLEN +: XLEN]
                                      : s[(k-1)*XLEN +: XLEN] ^ r[(k-1)*XLEN +: XLEN];
          acc_x = acc_x ^ r[(k-1)*XLEN +: XLEN];
          acc_s = acc_s + r[(k-1)*XLEN +: XLEN];
        end else if (k == ds) begin
          res[(k-1)*XLEN +: XLEN] = t ? s[(k-1)*XLEN +: XLEN] - acc_s
                                      : s[(k-1)*XLEN +: XLEN] ^ acc_x;
        end
      end
    end
    return res;
  endfunction

  function automatic logic [SW-1:0] merge_shares(input logic [SW-1:0]   old_v,
                                                 input logic [SW-1:0]   new_v,
                                                 input logic [SMAX-2:0] sel);
    logic [SW-1:0] res;
    res = old_v;
    for (int k = 0; k < SMAX-1; k++) begin
      if (sel[k]) res[k*XLEN +: XLEN] = new_v[k*XLEN +: XLEN];
    end
    return res;
  endfunction

  assign rs1_rdata = mem[rs1_addr];
  assign rs2_rdata = mem[rs2_addr];

  always_comb begin
    busy      = (state == ST_ZERO);
    wr_ready  = (state != ST_ZERO);
    // A pending zeroisation request outranks refresh, so no randomness is taken.
    rng_ready = (state == ST_REFRESH) && !wr_valid && !zero_req;
    wr_fire   = wr_valid && wr_ready;
    rf_fire   = rng_valid && rng_ready;
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    cnt_n   = cnt;
    step_n  = rf_fire;
    if (zero_req) begin
      state_n = ST_ZERO;
      ptr_n   = '0;
    end else begin
      unique case (state)
        ST_ZERO: begin
          if (ptr == AW'(NREGS-1)) begin
            ptr_n   = '0;
            state_n = ST_IDLE;
          end else begin
            ptr_n = ptr + AW'(1);
          end
        end
        ST_IDLE: begin
          if (refresh_en) begin
            state_n = ST_WAIT;
            cnt_n   = CW'(REFRESH_PERIOD-1);
          end
        end
        ST_WAIT: begin
          if (!refresh_en)    state_n = ST_IDLE;
          else if (cnt == '0) state_n = ST_REFRESH;
          else                cnt_n   = cnt - CW'(1);
        end
        ST_REFRESH: begin
          if (rf_fire) begin
            ptr_n   = ptr + AW'(1);
            state_n = ST_WAIT;
            cnt_n   = CW'(REFRESH_PERIOD-1);
          end else if (!refresh_en) begin
            state_n = ST_IDLE;
          end
        end
        default: state_n = ST_ZERO;
      endcase
    end
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state        <= ST_ZERO;
      ptr          <= '0;
      cnt          <= '0;
      refresh_step <= 1'b0;
    end else begin
      state        <= state_n;
      ptr          <= ptr_n;
      cnt          <= cnt_n;
      refresh_step <= step_n;
    end
  end

  // Share storage: not reset; zeroisation sweep, external write and refresh
  // commit are mutually exclusive by construction of the ready signals.
  always_ff @(posedge g_clk) begin
    if (!g_reset) begin
      if (state == ST_ZERO)  mem[ptr]     <= '0;
      else if (wr_fire)      mem[wr_addr] <= merge_shares(mem[wr_addr], wr_data, wr_sel);
      else if (rf_fire)      mem[ptr]     <= refresh_shares(mem[ptr], rng_data, smectl_d, smectl_t);
    end
  end

endmodule

// File: doc/sme_share_store.md
# sme_share_store

Parameterised storage for the non-zero shares (1..SMAX-1) of masked SME registers, successor to the fixed SMAX-1 bank arrangement. Provides two combinational share-vector read ports and one share-selectable write port used for both result writeback and bank load. Adds a post-reset/on-demand zeroisation sweep and a background refresh engine that periodically remasks stored registers with fresh randomness while preserving the unmasked value. Sits between the SME ALU/crypto units and the RNG.

## Interface
- XLEN, 32, share width in bits
- SMAX, 4, max hardware shares, including GPR share 0; ≥2
- NREGS, 16, registers per share bank; power of two
- REFRESH_PERIOD, 64, cycles spent in WAIT between refresh steps; ≥1
- Let SW=(SMAX-1)*XLEN, AW=$clog2(NREGS). Share k (1..SMAX-1) occupies bits [(k-1)*XLEN +: XLEN] of any share vector.

- g_clk  in  1  global clock
- g_reset  in  1  reset, synchronous, active-high
- smectl_d  in  4  total shares in use (1..SMAX); values >SMAX are treated as SMAX
- smectl_t  in  1  masking type: 0 boolean (XOR), 1 arithmetic (mod 2^XLEN)
- rs1_addr, rs2_addr  in  AW  read addresses
- rs1_rdata, rs2_rdata  out  SW  share vectors of addressed registers
- wr_valid  in  1  write request
- wr_ready  out  1  write accepted when high
- wr_addr  in  AW  write register
- wr_sel  in  SMAX-1  per-share write enable (bit k-1 = share k); one-hot for bank loads
- wr_data  in  SW  write share vector
- zero_req  in  1  start zeroisation sweep (level sampled each cycle)
- refresh_en  in  1  enable background refresh
- rng_valid  in  1  randomness available
- rng_ready  out  1  randomness consumed when high with rng_valid
- rng_data  in  SW  random words r1..r(SMAX-1), same packing
- busy  out  1  zeroisation in progress
- refresh_step  out  1  one-cycle pulse: a refresh step completed

## Operation
- Ds = min(smectl_d,SMAX)-1 = number of stored active shares.
- FSM states ZERO, IDLE, WAIT, REFRESH; pointer ptr (AW bits); counter cnt.
- Reset: state ZERO, ptr=0, cnt=0, refresh_step=0; busy=1, wr_ready=0, rng_ready=0. Storage contents undefined until sweep ends.
- ZERO: every share of reg[ptr] written 0, ptr++. At ptr==NREGS-1: ptr←0, next state IDLE. zero_req high in any state (including ZERO) forces ZERO with ptr←0 next cycle; highest priority.
- IDLE: refresh_en=1 → WAIT, cnt←REFRESH_PERIOD-1.
- WAIT: cnt--; at cnt==0 → REFRESH. refresh_en=0 → IDLE.
- REFRESH: rng_ready = !wr_valid. On rng_valid&&rng_ready: update reg[ptr], ptr←ptr+1 (wraps NREGS-1→0), refresh_step=1 next cycle, → WAIT with cnt reload. refresh_en=0 with no handshake that cycle → IDLE; ptr retained.
- Refresh update, Ds≥2: for k=1..Ds-1, s_k ← s_k ⊕ r_k (t=0) or s_k + r_k (t=1); s_Ds ← s_Ds ⊕ (⊕ r_1..r_(Ds-1)) or s_Ds − Σr_1..r_(Ds-1). Unmasked value unchanged. Shares >Ds untouched. Ds<2: handshake and ptr advance occur, no data change.
- Writes: wr_ready=1 in all states except ZERO; on wr_valid&&wr_ready, shares with wr_sel set written, others kept; smectl_d ignored.
- External write has priority: refresh never commits in a cycle with wr_valid high, so no same-cycle collision.
- Arithmetic mod 2^XLEN, carries discarded.

## Timing
- Reads combinational; a write or refresh at edge n visible on rdata after edge n.
- Zeroisation: busy high exactly NREGS cycles after reset deassert or zero_req drop.
- Refresh cadence without stalls: REFRESH_PERIOD WAIT cycles + 1 REFRESH cycle per register; full sweep NREGS*(REFRESH_PERIOD+1) cycles.
- refresh_step asserted the cycle after handshake, for one cycle.
- Reset mid-refresh or mid-write: no commit at that edge; ZERO restarts.

## Test plan
- Reset, hold 1 cycle, release -> busy high 16 cycles, wr_ready low; then all rdata 0, busy 0.
- Write addr 3 sel=3'b111 data {0x3,0x2,0x1}, then sel=3'b010 data share2=0xAA -> rs1_addr=3 reads {0x3,0xAA,0x1}.
- smectl_d=4,t=0, REFRESH_PERIOD=4, reg0 shares {0x3,0x2,0x1}, rng {0,0xF0,0x0F} -> after step reg0 = {0x3^0xFF,0x2^0xF0,0x1^0x0F}, XOR of shares unchanged, refresh_step pulse, ptr=1.
- smectl_d=4,t=1, reg0 {5,3,1}, rng r1=2,r2=0xFFFFFFFF -> {5-1 mod 2^32 = 4 with carry rule: s3=5-(2+0xFFFFFFFF)=4, s2=2, s1=3}; sum unchanged.
- wr_valid held high during REFRESH -> rng_ready 0, no refresh until wr_valid drops; smectl_d=2 -> step occurs, data unchanged.
- zero_req mid-refresh at ptr=7 -> next cycle busy=1, ptr=0, 16-cycle sweep, contents zero.
